// File: rtl/fpcvt_seq_ctrl_if.sv
// fpcvt_seq_ctrl_if: sample-in / float-out valid-ready handshake bundle for fpcvt_seq_ctrl.
interface fpcvt_seq_ctrl_if;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_s;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_s, out_e, out_f, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_s, out_e, out_f, out_valid
    );
endinterface

// File: rtl/fpcvt_seq_ctrl.sv
// fpcvt_seq_ctrl: 12-bit two's-complement to 1/3/4 float, one normalisation shift per cycle.
// Define FPCVT_BACK2BACK_EN to let DONE retire a result and accept the next sample on one edge.
module fpcvt_seq_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    fpcvt_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [10:0] mag_q, mag_d;
    logic [2:0]  e_q, e_d;
    logic        out_s_q, out_s_d;
    logic [2:0]  out_e_q, out_e_d;
    logic [3:0]  out_f_q, out_f_d;
    logic        out_valid_q, out_valid_d;
    logic [11:0] neg_in;
    logic [10:0] abs_in;
    logic [3:0]  f_c;
    logic        accept;

    assign neg_in = -bus.in_data;
    // -2048 has no 11-bit magnitude, so it clamps to the largest one
    assign abs_in = !bus.in_data[11] ? bus.in_data[10:0] :
                    (bus.in_data == 12'h800) ? 11'h7FF : neg_in[10:0];
    assign f_c    = mag_q[10:7];
`ifdef FPCVT_BACK2BACK_EN
    assign bus.in_ready = rst_n && (state_q == IDLE || (state_q == DONE && bus.out_ready));
`else
    assign bus.in_ready = rst_n && state_q == IDLE;
`endif
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_s     = out_s_q;
    assign bus.out_e     = out_e_q;
    assign bus.out_f     = out_f_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        e_d         = e_q;
        out_s_d     = out_s_q;
        out_e_d     = out_e_q;
        out_f_d     = out_f_q;
        out_valid_d = out_valid_q;
        case (state_q)
            NORM: begin
                if (!mag_q[10] && e_q != 3'd0) begin
                    mag_d = mag_q << 1;
                    e_d   = e_q - 3'd1;
                end else begin
                    out_f_d     = !mag_q[6] ? f_c : (f_c != 4'd15) ? f_c + 4'd1 :
                                  (e_q != 3'd7) ? 4'b1000 : 4'd15;
                    out_e_d     = (mag_q[6] && f_c == 4'd15 && e_q != 3'd7) ? e_q + 3'd1 : e_q;
                    out_s_d     = sign_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            sign_d  = bus.in_data[11];
            mag_d   = abs_in;
            e_d     = 3'd7;
            state_d = NORM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            e_q         <= '0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            e_q         <= e_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// tb_fpcvt_seq_ctrl: directed vector table, reset/hold/back-to-back sequences and random samples vs. a value-level model.
module tb_fpcvt_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    fpcvt_seq_ctrl_if bus ();
    fpcvt_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x;
        int          lat;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        int          hold;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Value-level reference: round |x| to F*2^E with F in 4 bits, E in 3 bits
    task automatic model(input logic [11:0] x, output int lat, output logic s,
                         output logic [2:0] e, output logic [3:0] f);
        int v, m, p, ee, ff;
        v = int'($signed(x));
        s = v < 0;
        m = v < 0 ? -v : v;
        if (m > 2047) m = 2047;
        if (m < 16) begin
            lat = 8; ee = 0; ff = m;
        end else begin
            p = 10;
            while (((m >> p) & 1) == 0) p--;
            ee  = p - 3;
            ff  = (m >> (p - 3)) + ((m >> (p - 4)) & 1);
            if (ff == 16) begin
                if (ee < 7) begin ff = 8; ee++; end
                else ff = 15;
            end
            lat = 11 - p;
        end
        e = 3'(ee);
        f = 4'(ff);
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        chk("in_ready_idle", int'(bus.in_ready), 1);
        bus.in_data   = v.x;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, v.lat);
        chk("out_s", int'(bus.out_s), int'(v.s));
        chk("out_e", int'(bus.out_e), int'(v.e));
        chk("out_f", int'(bus.out_f), int'(v.f));
        for (int i = 0; i < v.hold; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = 12'($urandom);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_sef", int'({bus.out_s, bus.out_e, bus.out_f}), int'({v.s, v.e, v.f}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("retire_valid", int'(bus.out_valid), 0);
        chk("retire_keep", int'({bus.out_s, bus.out_e, bus.out_f}), int'({v.s, v.e, v.f}));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   seen;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vecs = '{
            '{12'd125, 5, 1'b0, 3'd4, 4'd8,  0},
            '{12'hFFF, 8, 1'b1, 3'd0, 4'd1,  0},
            '{12'h000, 8, 1'b0, 3'd0, 4'd0,  0},
            '{12'h800, 1, 1'b1, 3'd7, 4'd15, 0},
            '{12'h7FF, 1, 1'b0, 3'd7, 4'd15, 0},
            '{12'd422, 3, 1'b0, 3'd5, 4'd13, 5},
            '{12'd5,   8, 1'b0, 3'd0, 4'd5,  0},
            '{12'd16,  7, 1'b0, 3'd1, 4'd8,  0}
        };

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_sef", int'({bus.out_s, bus.out_e, bus.out_f}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) send(vecs[i]);

        // Reset in the middle of normalising 12'h001 must discard it
        bus.in_data  = 12'h001;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        chk("midrst_sef", int'({bus.out_s, bus.out_e, bus.out_f}), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_stale", seen, 0);
        chk("midrst_in_ready_after", int'(bus.in_ready), 1);

        for (int i = 0; i < 40; i++) begin
            logic signed [11:0] t;
            t = 12'($urandom);
            t = t >>> $urandom_range(0, 11);
            v.x = t;
            v.hold = int'($urandom_range(0, 2));
            model(v.x, v.lat, v.s, v.e, v.f);
            send(v);
        end

`ifdef FPCVT_BACK2BACK_EN
        begin
            int n = 0;
            bus.in_data   = 12'd125;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.in_data = 12'd5;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_lat1", n, 5);
            chk("b2b_sef1", int'({bus.out_s, bus.out_e, bus.out_f}), int'({1'b0, 3'd4, 4'd8}));
            chk("b2b_in_ready_done", int'(bus.in_ready), 1);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("b2b_retired", int'(bus.out_valid), 0);
            chk("b2b_busy", int'(bus.in_ready), 0);
            n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_lat2", n, 8);
            chk("b2b_sef2", int'({bus.out_s, bus.out_e, bus.out_f}), int'({1'b0, 3'd0, 4'd5}));
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("b2b_end", int'(bus.out_valid), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
